// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the seq_div signed restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int calc_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Helpers work on a 64-bit sign-extended value; callers size-cast the result back.
  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  function automatic logic [63:0] abs64(input logic [63:0] x);
    return x[63] ? neg64(x) : x;
  endfunction

endpackage

// File: rtl/seq_div_lzc.sv
// Priority encoder: index of the most significant set bit (0 when the input is zero).
module seq_div_lzc #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] i_val,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_val[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/seq_div.sv
// Iterative signed restoring divider, one quotient bit per clock, valid/ready on both sides.
// Build option SEQ_DIV_EARLY_TERM_EN skips the leading-zero iterations of |dividend|.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH_N-1:0] din_n,
  input  logic signed [WIDTH_D-1:0] din_d,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic        [WIDTH_N-1:0] dout_q,
  output logic        [WIDTH_D-1:0] dout_r,
  output logic                      div_by_zero
);

  localparam int CNT_W = calc_cnt_w(WIDTH_N);

  state_t               r_state, w_state_nx;
  logic                 r_sign_n, r_sign_d;
  logic [WIDTH_N-1:0]   r_n, r_q, r_dout_q;
  logic [WIDTH_D-1:0]   r_d, r_rem, r_dout_r;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_out_valid, r_dbz;

  logic [WIDTH_N-1:0]   w_n_abs, w_q_res;
  logic [WIDTH_D-1:0]   w_d_abs, w_r_res, w_rem_nx;
  logic [WIDTH_D:0]     w_rem_sh;
  logic [CNT_W-1:0]     w_cnt_start;
  logic                 w_d_zero, w_accept, w_fits;

  assign w_n_abs  = WIDTH_N'(abs64(64'(din_n)));
  assign w_d_abs  = WIDTH_D'(abs64(64'(din_d)));
  assign w_d_zero = (din_d == '0);
  assign w_accept = in_valid && (r_state == IDLE);

`ifdef SEQ_DIV_EARLY_TERM_EN
  seq_div_lzc #(.WIDTH(WIDTH_N), .IDX_W(CNT_W)) u_lzc (
    .i_val (w_n_abs),
    .o_idx (w_cnt_start)
  );
`else
  assign w_cnt_start = CNT_W'(WIDTH_N - 1);
`endif

  // Remainder stays below |d| <= 2^(WIDTH_D-1), so the shifted value fits WIDTH_D+1 bits.
  assign w_rem_sh = {r_rem, r_n[r_cnt]};
  assign w_fits   = (w_rem_sh >= {1'b0, r_d});
  assign w_rem_nx = w_fits ? WIDTH_D'(w_rem_sh - {1'b0, r_d}) : w_rem_sh[WIDTH_D-1:0];

  assign w_q_res = (r_sign_n ^ r_sign_d) ? WIDTH_N'(neg64(64'(r_q))) : r_q;
  assign w_r_res = r_sign_n ? WIDTH_D'(neg64(64'(r_rem))) : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE: if (in_valid) w_state_nx = w_d_zero ? DONE : CALC;
      CALC: if (r_cnt == '0) w_state_nx = FIX;
      FIX:  w_state_nx = DONE;
      DONE: if (r_out_valid && out_ready) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign_n    <= 1'b0;
      r_sign_d    <= 1'b0;
      r_n         <= '0;
      r_d         <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_dout_q    <= '0;
      r_dout_r    <= '0;
      r_out_valid <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_sign_n <= din_n[WIDTH_N-1];
          r_sign_d <= din_d[WIDTH_D-1];
          r_n      <= w_n_abs;
          r_d      <= w_d_abs;
          r_cnt    <= w_cnt_start;
          r_q      <= '0;
          // Zero divisor parks the raw dividend low bits here for the result load in DONE.
          r_rem    <= w_d_zero ? din_n[WIDTH_D-1:0] : '0;
        end
        CALC: begin
          r_rem <= w_rem_nx;
          r_q   <= {r_q[WIDTH_N-2:0], w_fits};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        FIX: begin
          r_dout_q    <= w_q_res;
          r_dout_r    <= w_r_res;
          r_dbz       <= 1'b0;
          r_out_valid <= 1'b1;
        end
        DONE: begin
          // DONE without a valid result can only come from the zero-divisor path.
          if (!r_out_valid) begin
            r_dout_q    <= '1;
            r_dout_r    <= r_rem;
            r_dbz       <= 1'b1;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_out_valid;
  assign dout_q      = r_dout_q;
  assign dout_r      = r_dout_r;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (WIDTH_N=16, WIDTH_D=8).
module tb_seq_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] din_n = '0;
  logic [7:0]  din_d = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] dout_q;
  logic [7:0]  dout_r;
  logic        div_by_zero;

  int n_chk = 0;
  int n_fail = 0;

  seq_div #(.WIDTH_N(16), .WIDTH_D(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .din_n       (din_n),
    .din_d       (din_d),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dout_q      (dout_q),
    .dout_r      (dout_r),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] n, input logic [7:0] d);
    int lat;
    logic [15:0] a;
    a = n[15] ? (~n + 16'd1) : n;
    lat = 17;
    if (d == 8'd0) lat = 1;
`ifdef SEQ_DIV_EARLY_TERM_EN
    else begin
      lat = 2;
      for (int i = 0; i < 16; i++) if (a[i]) lat = i + 2;
    end
`else
    if (a == 16'hFFFF) lat = 0;
`endif
    return lat;
  endfunction

  // Start one operation (caller is just past an edge, DUT in IDLE); returns edges until out_valid.
  task automatic start_op(input logic [15:0] n, input logic [7:0] d, output int lat);
    din_n    = n;
    din_d    = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_div(input string tag, input logic [15:0] n, input logic [7:0] d,
                         input logic [15:0] eq, input logic [7:0] er, input logic edbz);
    int lat;
    check({tag, " in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    start_op(n, d, lat);
    check({tag, " latency"}, lat, exp_lat(n, d));
    check({tag, " q"}, {16'd0, dout_q}, {16'd0, eq});
    check({tag, " r"}, {24'd0, dout_r}, {24'd0, er});
    check({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    @(posedge clk); #1;
    check({tag, " valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [15:0] hq;
    logic [7:0]  hr;
    #3;
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst q", {16'd0, dout_q}, 32'd0);
    check("rst r", {24'd0, dout_r}, 32'd0);
    check("rst dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_div("100/7",     16'd100,   8'd7,   16'd14,   8'd2,   1'b0);
    run_div("-100/7",    16'hFF9C,  8'd7,   16'hFFF2, 8'hFE,  1'b0);
    run_div("100/-7",    16'd100,   8'hF9,  16'hFFF2, 8'd2,   1'b0);
    run_div("-100/-7",   16'hFF9C,  8'hF9,  16'd14,   8'hFE,  1'b0);
    run_div("-32768/-1", 16'h8000,  8'hFF,  16'h8000, 8'd0,   1'b0);
    run_div("32767/1",   16'h7FFF,  8'd1,   16'h7FFF, 8'd0,   1'b0);
    run_div("1234/0",    16'd1234,  8'd0,   16'hFFFF, 8'hD2,  1'b1);
    run_div("10/3",      16'd10,    8'd3,   16'd3,    8'd1,   1'b0);
    run_div("7/9",       16'd7,     8'd9,   16'd0,    8'd7,   1'b0);
    run_div("-1/-128",   16'hFFFF,  8'h80,  16'd0,    8'hFF,  1'b0);

    // Backpressure with in_valid held high throughout.
    out_ready = 1'b0;
    din_n = 16'd200;
    din_d = 8'd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp accepted", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp latency", lat, exp_lat(16'd200, 8'd9));
    hq = dout_q;
    hr = dout_r;
    check("bp q", {16'd0, hq}, 32'd22);
    check("bp r", {24'd0, hr}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp hold valid", {31'd0, out_valid}, 32'd1);
      check("bp hold in_ready", {31'd0, in_ready}, 32'd0);
      check("bp hold q", {16'd0, dout_q}, 32'd22);
      check("bp hold r", {24'd0, dout_r}, 32'd2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release valid", {31'd0, out_valid}, 32'd0);
    check("bp release in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("bp reaccept", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp2 latency", lat, exp_lat(16'd200, 8'd9));
    check("bp2 q", {16'd0, dout_q}, 32'd22);
    @(posedge clk); #1;

    // Reset in the middle of a calculation.
    din_n = 16'd1000;
    din_d = 8'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst q", {16'd0, dout_q}, 32'd0);
    check("midrst r", {24'd0, dout_r}, 32'd0);
    check("midrst dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-rst no result", {31'd0, out_valid}, 32'd0);
    run_div("50/-6", 16'd50, 8'hFA, 16'hFFF8, 8'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
